mmio_fifo_ctrl: RTL
===================

# mmio_fifo_ctrl

Memory-mapped FIFO controller on the CCI-P MMIO path of the AFU. It takes decoded MMIO writes and reads from the AFU's c0 handling and implements a DEPTH-entry circular buffer in a small register window: push, pop, peek, status and flush. Read data and TID are returned one cycle later, ready for the AFU to drive onto tx.c2. Addresses outside the window are ignored; the AFU answers those itself.

## Interface
- WIDTH, 64: data width of each entry and of the MMIO data bus.
- DEPTH, 8: number of entries; power of two, at least 2.
- BASE_ADDR, 16'h0020: MMIO word address of the data register. Must be even.
- clk  in  1  sole clock.
- rst  in  1  reset, asynchronous, active-high.
- wr_valid  in  1  MMIO write strobe (rx.c0.mmioWrValid).
- wr_addr  in  16  MMIO write address.
- wr_data  in  WIDTH  MMIO write data.
- rd_valid  in  1  MMIO read strobe (rx.c0.mmioRdValid).
- rd_addr  in  16  MMIO read address.
- rd_tid  in  9  MMIO read TID.
- rsp_valid  out  1  read response valid, one cycle wide.
- rsp_tid  out  9  TID echoed from the matching read.
- rsp_data  out  WIDTH  read response data.
- count  out  $clog2(DEPTH)+1  current occupancy, for debug.

## Operation
- Storage:
  - DEPTH x WIDTH array, plus head pointer and tail pointer of $clog2(DEPTH) bits each, plus a count register.
  - Pointers wrap modulo DEPTH.
  - The array itself is not reset.
- DATA register, BASE_ADDR:
  - Write: push wr_data at tail when count < DEPTH. When full, drop the data and set the sticky OVF flag.
  - Read: return the head entry and pop it. When empty, return 0, set the sticky UNF flag, and leave the pointers unchanged.
- STATUS register, BASE_ADDR+2:
  - Read layout: [15:0] count (zero-extended), [16] empty, [17] full, [18] OVF, [19] UNF; all other bits 0.
  - Write: W1C. wr_data[18] clears OVF; wr_data[19] clears UNF. Other bits are ignored.
- PEEK/FLUSH register, BASE_ADDR+4:
  - Read: return the head entry without popping, or 0 when empty. Does not set UNF.
  - Write (any data): head, tail and count go to 0. OVF and UNF are unchanged.
- Odd addresses and other addresses in the window: reads return 0 with rsp_valid; writes are ignored.
- Addresses outside [BASE_ADDR, BASE_ADDR+5]: no response and no state change.
- Simultaneous rd_valid and wr_valid in the same cycle: the read result is computed from pre-cycle state, then both effects apply.
  - Pop + push while full: both succeed, count is unchanged, OVF is not set.
  - Pop + push while empty: pop returns 0 and sets UNF; the push succeeds, so count becomes 1.
  - Pop + flush: the pop returns the old head; the final state is empty.
  - STATUS read + W1C write: the read returns the pre-clear flags.
- Set and clear of the same sticky flag in one cycle: set wins.

## Timing
- Reset: rsp_valid=0, rsp_tid=0, rsp_data=0, count=0, head=tail=0, OVF=UNF=0.
- Read latency:
  - rd_valid in cycle N gives rsp_valid=1 in cycle N+1 with rsp_tid and rsp_data registered.
  - rsp_valid falls in N+2 unless another in-window read arrives in N+1.
  - rsp_data and rsp_tid hold their last value while rsp_valid=0.
- Back-to-back reads: one per cycle, all accepted; there is no backpressure.
- State effects: pointer, count and flag updates are visible to a read issued in the next cycle.
- Reset asserted mid-operation: all state clears immediately (asynchronously), and any pending response is lost.

## Test plan
- Reset, then read STATUS -> after 1 cycle, rsp_valid=1, rsp_data=64'h1_0000 (empty set), count=0.
- Push 1..8 to DEPTH=8, then a ninth push of 9 -> STATUS = 0x0006_0008 (full, OVF, count=8); popping 8 times returns 1..8 in order.
- Pop when empty with tid=9'h15 -> rsp_tid=9'h15, rsp_data=0, UNF=1; write STATUS with bit19=1 -> UNF=0.
- Push A, B, peek twice, then pop -> both peeks return A and the pop returns A; count goes 2 -> 1.
- Fill to 8, then pop and push 0x55 in the same cycle -> pop returns the oldest entry, count stays 8, OVF=0; 20 push/pop cycles verify pointer wrap-around with correct order.
- Push 3 entries, write FLUSH, then pop -> returns 0, UNF=1, count=0; a read at 16'h0030 gives no rsp_valid.

Source files
------------

// File: rtl/mmio_fifo_ctrl.sv
// mmio_fifo_ctrl: DEPTH-entry circular FIFO behind a small MMIO window with DATA (push/pop),
// STATUS (W1C sticky flags) and PEEK/FLUSH registers; read data and TID return one cycle later.
module mmio_fifo_ctrl #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned DEPTH     = 8,
  parameter logic [15:0] BASE_ADDR = 16'h0020
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  input  logic [15:0]              wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_valid,
  input  logic [15:0]              rd_addr,
  input  logic [8:0]               rd_tid,
  output logic                     rsp_valid,
  output logic [8:0]               rsp_tid,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [15:0] OFF_DATA   = 16'd0;
  localparam logic [15:0] OFF_STATUS = 16'd2;
  localparam logic [15:0] OFF_PEEK   = 16'd4;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [8:0]       rsp_tid_q, rsp_tid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  // Offsets wrap below BASE_ADDR, so one unsigned compare bounds the window on both sides.
  logic [15:0] rd_off, wr_off;
  logic        rd_hit, wr_hit;
  assign rd_off = rd_addr - BASE_ADDR;
  assign wr_off = wr_addr - BASE_ADDR;
  assign rd_hit = rd_valid && (rd_off < 16'd6);
  assign wr_hit = wr_valid && (wr_off < 16'd6);

  logic empty, full, rd_pop, wr_push, wr_w1c, wr_flush;
  logic pop_ok, push_ok, ovf_set, unf_set;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign rd_pop   = rd_hit && (rd_off == OFF_DATA);
  assign wr_push  = wr_hit && (wr_off == OFF_DATA);
  assign wr_w1c   = wr_hit && (wr_off == OFF_STATUS);
  assign wr_flush = wr_hit && (wr_off == OFF_PEEK);
  assign pop_ok   = rd_pop && !empty;
  assign push_ok  = wr_push && (!full || pop_ok);
  assign ovf_set  = wr_push && full && !pop_ok;
  assign unf_set  = rd_pop && empty;

  logic unused_wr_bits;
  assign unused_wr_bits = ^{wr_data[WIDTH-1:20], wr_data[17:0]};

  logic [WIDTH-1:0] status_word, rd_word;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    status_word       = '0;
    status_word[15:0] = 16'(count_q);
    status_word[16]   = empty;
    status_word[17]   = full;
    status_word[18]   = ovf_q;
    status_word[19]   = unf_q;

    rd_word = '0;
    if ((rd_off == OFF_DATA || rd_off == OFF_PEEK) && !empty) rd_word = mem_q[head_q];
    else if (rd_off == OFF_STATUS)                            rd_word = status_word;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (wr_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop_ok)  head_d = head_q + AW'(1);
      if (push_ok) tail_d = tail_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
    // Set has priority over a same-cycle W1C clear.
    ovf_d = (ovf_q & ~(wr_w1c & wr_data[18])) | ovf_set;
    unf_d = (unf_q & ~(wr_w1c & wr_data[19])) | unf_set;

    rsp_valid_d = rd_hit;
    rsp_tid_d   = rd_hit ? rd_tid  : rsp_tid_q;
    rsp_data_d  = rd_hit ? rd_word : rsp_data_q;
  end

  // NOTE: the storage array has no reset; entries are only ever read after being pushed,
  // and empty reads are forced to zero, so resetting it would buy nothing.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[tail_q] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_tid_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_tid_q   <= rsp_tid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_tid   = rsp_tid_q;
  assign rsp_data  = rsp_data_q;
  assign count     = count_q;

endmodule
